// File: rtl/poly_seg_pkg.sv
// Shared types and widths for the segment sequencer feeding the cubic evaluator.
// Widths must track the evaluator's coefficient/time widths.
package poly_seg_pkg;

  localparam int BC = 16;  // coefficient width, two's complement
  localparam int BT = 16;  // time width, unsigned fraction
  localparam int BN = 16;  // sample-count width

  typedef struct packed {
    logic [BC-1:0] c0;
    logic [BC-1:0] c1;
    logic [BC-1:0] c2;
    logic [BC-1:0] c3;
    logic [BT-1:0] dt;
    logic [BN-1:0] n;
    logic          seg_end;
  } seg_desc_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/seg_desc_buf.sv
// One-entry descriptor buffer: captured on handshake, released when the sequencer loads it.
// ready is registered so it reads 0 during reset and rises on the first edge after release.
module seg_desc_buf
  import poly_seg_pkg::*;
(
  input  logic      clk,
  input  logic      rstn,
  input  logic      wr,
  input  seg_desc_t wr_desc,
  input  logic      rd,
  output seg_desc_t rd_desc,
  output logic      full,
  output logic      ready
);

  logic full_next;

  // A write only happens while empty and a read only while full, so they never collide.
  assign full_next = wr | (full & ~rd);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_desc <= '0;
      full    <= 1'b0;
      ready   <= 1'b0;
    end else begin
      // NOTE: state updates use <= so every register samples pre-edge values.
      full  <= full_next;
      ready <= ~full_next;
      if (wr) rd_desc <= wr_desc;
    end
  end

endmodule

// File: rtl/poly_seg_seq.sv
// Segment sequencer: turns piecewise-cubic descriptors into a per-sample t ramp plus coefficients.
// Define POLY_SEG_SEQ_HOLD_EN to hold t/coefficients when idle instead of forcing them to 0.
module poly_seg_seq
  import poly_seg_pkg::*;
(
  input  logic          clk,
  input  logic          rstn,
  input  logic [BC-1:0] s_c0,
  input  logic [BC-1:0] s_c1,
  input  logic [BC-1:0] s_c2,
  input  logic [BC-1:0] s_c3,
  input  logic [BT-1:0] s_dt,
  input  logic [BN-1:0] s_n,
  input  logic          s_end,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [BT-1:0] t_out,
  output logic [BC-1:0] c0_out,
  output logic [BC-1:0] c1_out,
  output logic [BC-1:0] c2_out,
  output logic [BC-1:0] c3_out,
  output logic          m_valid,
  output logic          m_last,
  output logic          busy,
  output logic          underrun
);

  seg_desc_t     s_desc, buf_desc;
  logic          buf_full, buf_rd;
  state_t        state;
  logic [BT-1:0] t_acc, cur_dt;
  logic [BN-1:0] cnt;
  logic          cur_end;

  assign s_desc = '{c0: s_c0, c1: s_c1, c2: s_c2, c3: s_c3,
                    dt: s_dt, n: s_n, seg_end: s_end};

  // The buffer is consumed when idle, or in RUN on the cycle the last sample is out.
  assign buf_rd = buf_full & ((state == IDLE) | (cnt == '0));

  seg_desc_buf u_buf (
    .clk     (clk),
    .rstn    (rstn),
    .wr      (s_valid & s_ready),
    .wr_desc (s_desc),
    .rd      (buf_rd),
    .rd_desc (buf_desc),
    .full    (buf_full),
    .ready   (s_ready)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      t_acc    <= '0;
      cur_dt   <= '0;
      cnt      <= '0;
      cur_end  <= 1'b0;
      t_out    <= '0;
      c0_out   <= '0;
      c1_out   <= '0;
      c2_out   <= '0;
      c3_out   <= '0;
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
      busy     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (buf_rd && (buf_desc.n != '0)) begin
        // Load: first sample (t=0) is presented straight away; t_acc already holds the next t.
        state   <= RUN;
        busy    <= 1'b1;
        t_acc   <= buf_desc.dt;
        cur_dt  <= buf_desc.dt;
        cnt     <= buf_desc.n - BN'(1);
        cur_end <= buf_desc.seg_end;
        t_out   <= '0;
        c0_out  <= buf_desc.c0;
        c1_out  <= buf_desc.c1;
        c2_out  <= buf_desc.c2;
        c3_out  <= buf_desc.c3;
        m_valid <= 1'b1;
        m_last  <= (buf_desc.n == BN'(1));
      end else if ((state == RUN) && (cnt != '0)) begin
        t_out  <= t_acc;
        t_acc  <= t_acc + cur_dt;
        cnt    <= cnt - BN'(1);
        m_last <= (cnt == BN'(1));
      end else if ((state == RUN) || buf_rd) begin
        // Segment finished with nothing to follow, or a zero-length descriptor was dropped.
        state    <= IDLE;
        busy     <= 1'b0;
        m_valid  <= 1'b0;
        m_last   <= 1'b0;
        underrun <= (state == RUN) && !buf_rd && !cur_end;
`ifndef POLY_SEG_SEQ_HOLD_EN
        t_out    <= '0;
        c0_out   <= '0;
        c1_out   <= '0;
        c2_out   <= '0;
        c3_out   <= '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_poly_seg_seq.sv
// Self-checking bench for poly_seg_seq: scoreboard of expected samples checked by a negedge monitor.
module tb_poly_seg_seq;
  import poly_seg_pkg::*;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [BC-1:0] s_c0 = '0, s_c1 = '0, s_c2 = '0, s_c3 = '0;
  logic [BT-1:0] s_dt = '0;
  logic [BN-1:0] s_n = '0;
  logic          s_end = 1'b0, s_valid = 1'b0;
  logic          s_ready;
  logic [BT-1:0] t_out;
  logic [BC-1:0] c0_out, c1_out, c2_out, c3_out;
  logic          m_valid, m_last, busy, underrun;

  always #5 clk = ~clk;

  poly_seg_seq dut (
    .clk(clk), .rstn(rstn),
    .s_c0(s_c0), .s_c1(s_c1), .s_c2(s_c2), .s_c3(s_c3),
    .s_dt(s_dt), .s_n(s_n), .s_end(s_end), .s_valid(s_valid), .s_ready(s_ready),
    .t_out(t_out), .c0_out(c0_out), .c1_out(c1_out), .c2_out(c2_out), .c3_out(c3_out),
    .m_valid(m_valid), .m_last(m_last), .busy(busy), .underrun(underrun)
  );

  typedef struct {
    logic [BT-1:0] t;
    logic [BC-1:0] c0, c1, c2, c3;
    logic          last;
  } samp_t;

  samp_t exp_q[$];
  samp_t mon_e;
  samp_t last_exp = '{default: '0};
  int    errors = 0, checks = 0;
  int    n_valid = 0, run_len = 0, max_run = 0, n_underrun = 0;
  time   last_valid_t = 0, underrun_t = 0, first_valid_t = 0;
  bit    first_seen = 0;

  // Monitor: every sample cycle is matched against the scoreboard; idle cycles against the idle value.
  always @(negedge clk) begin
    if (rstn) begin
      checks++;
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_sample at %0t: t_out=%h, none expected", $time, t_out);
        end else begin
          mon_e = exp_q.pop_front();
          if ({t_out, c0_out, c1_out, c2_out, c3_out, m_last} !==
              {mon_e.t, mon_e.c0, mon_e.c1, mon_e.c2, mon_e.c3, mon_e.last}) begin
            errors++;
            $display("FAIL sample at %0t: got t=%h c=%h/%h/%h/%h last=%b, want t=%h c=%h/%h/%h/%h last=%b",
                     $time, t_out, c0_out, c1_out, c2_out, c3_out, m_last,
                     mon_e.t, mon_e.c0, mon_e.c1, mon_e.c2, mon_e.c3, mon_e.last);
          end
          last_exp = mon_e;
        end
        n_valid++;
        run_len++;
        if (run_len > max_run) max_run = run_len;
        last_valid_t = $time;
        if (!first_seen) begin
          first_seen    = 1;
          first_valid_t = $time;
        end
      end else begin
        run_len = 0;
`ifdef POLY_SEG_SEQ_HOLD_EN
        mon_e = last_exp;
`else
        mon_e = '{default: '0};
`endif
        if ({t_out, c0_out, c1_out, c2_out, c3_out, m_last} !==
            {mon_e.t, mon_e.c0, mon_e.c1, mon_e.c2, mon_e.c3, 1'b0}) begin
          errors++;
          $display("FAIL idle_outputs at %0t: got t=%h c0=%h last=%b, want t=%h c0=%h last=0",
                   $time, t_out, c0_out, m_last, mon_e.t, mon_e.c0);
        end
      end
      if (underrun) begin
        n_underrun++;
        underrun_t = $time;
      end
    end
  end

  function automatic seg_desc_t mk(input logic [BC-1:0] c0, c1, c2, c3,
                                   input logic [BT-1:0] dt, input logic [BN-1:0] n,
                                   input logic e);
    seg_desc_t d;
    d = '{c0: c0, c1: c1, c2: c2, c3: c3, dt: dt, n: n, seg_end: e};
    return d;
  endfunction

  // Reference model: t_k = k*dt modulo 2^BT, last flag on the final sample.
  task automatic push_seg(input seg_desc_t d);
    logic [BT-1:0] t;
    t = '0;
    for (int i = 0; i < int'(d.n); i++) begin
      exp_q.push_back('{t: t, c0: d.c0, c1: d.c1, c2: d.c2, c3: d.c3, last: (i == int'(d.n) - 1)});
      t = t + d.dt;
    end
  endtask

  task automatic send(input seg_desc_t d, output time hs_t);
    int guard;
    @(negedge clk);
    s_c0 = d.c0; s_c1 = d.c1; s_c2 = d.c2; s_c3 = d.c3;
    s_dt = d.dt; s_n = d.n; s_end = d.seg_end; s_valid = 1'b1;
    guard = 0;
    while (!s_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (!s_ready) begin
      errors++;
      $display("FAIL send_timeout: s_ready=%b after %0d cycles, want 1", s_ready, guard);
      s_valid = 1'b0;
      hs_t = 0;
    end else begin
      @(posedge clk);
      hs_t = $time;
      #1 s_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d samples outstanding, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic clear_stats();
    n_valid = 0; run_len = 0; max_run = 0; n_underrun = 0; first_seen = 0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({s_ready, t_out, c0_out, c1_out, c2_out, c3_out, m_valid, m_last, busy, underrun} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: s_ready=%b t=%h m_valid=%b busy=%b, want all 0",
               s_ready, t_out, m_valid, busy);
    end
    @(negedge clk);
    #1 rstn = 1'b1;
    checks++;
    if (s_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_before_edge: s_ready=%b, want 0", s_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (s_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_after_edge: s_ready=%b busy=%b, want 1/0", s_ready, busy);
    end
  endtask

  task automatic test_single();
    seg_desc_t d;
    time hs;
    clear_stats();
    d = mk(16'h1000, 16'h0, 16'h0, 16'h0, 16'h0100, 16'd4, 1'b1);
    push_seg(d);
    send(d, hs);
    wait_drain("single");
    checks++;
    if (first_valid_t !== hs + 15) begin
      errors++;
      $display("FAIL single_latency: first m_valid at %0t, want %0t", first_valid_t, hs + 15);
    end
    checks++;
    if (n_valid !== 4 || max_run !== 4 || n_underrun !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_counts: valid=%0d run=%0d underrun=%0d busy=%b, want 4/4/0/0",
               n_valid, max_run, n_underrun, busy);
    end
  endtask

  task automatic test_back_to_back();
    seg_desc_t a, b;
    time hs;
    clear_stats();
    a = mk(16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0200, 16'd3, 1'b0);
    b = mk(16'hFF00, 16'h8001, 16'h7FFF, 16'h1234, 16'h0050, 16'd2, 1'b1);
    push_seg(a);
    push_seg(b);
    send(a, hs);
    send(b, hs);
    wait_drain("b2b");
    checks++;
    if (n_valid !== 5 || max_run !== 5 || n_underrun !== 0) begin
      errors++;
      $display("FAIL b2b_contiguous: valid=%0d run=%0d underrun=%0d, want 5/5/0",
               n_valid, max_run, n_underrun);
    end
  endtask

  task automatic test_underrun();
    seg_desc_t d;
    time hs;
    clear_stats();
    d = mk(16'h0777, 16'h0001, 16'h0002, 16'h0003, 16'h0400, 16'd2, 1'b0);
    push_seg(d);
    send(d, hs);
    wait_drain("underrun");
    checks++;
    if (n_underrun !== 1 || underrun_t !== last_valid_t + 10 || busy !== 1'b0) begin
      errors++;
      $display("FAIL underrun_pulse: count=%0d at %0t (last sample %0t) busy=%b, want 1 at last+10, busy 0",
               n_underrun, underrun_t, last_valid_t, busy);
    end
  endtask

  task automatic test_zero_len();
    seg_desc_t a, z, c;
    time hs;
    clear_stats();
    a = mk(16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0010, 16'd2, 1'b0);
    z = mk(16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D, 16'h1000, 16'd0, 1'b0);
    c = mk(16'h0505, 16'h0606, 16'h0707, 16'h0808, 16'h0020, 16'd2, 1'b1);
    push_seg(a);
    push_seg(c);
    send(a, hs);
    send(z, hs);
    send(c, hs);
    wait_drain("zero_len");
    checks++;
    if (n_valid !== 4 || n_underrun !== 0) begin
      errors++;
      $display("FAIL zero_len_counts: valid=%0d underrun=%0d, want 4/0", n_valid, n_underrun);
    end
  endtask

  task automatic test_wrap();
    seg_desc_t d;
    time hs;
    clear_stats();
    d = mk(16'h4000, 16'h0, 16'h0, 16'h0, 16'h8000, 16'd3, 1'b1);
    push_seg(d);
    checks++;
    if (exp_q[2].t !== 16'h0000 || exp_q[1].t !== 16'h8000) begin
      errors++;
      $display("FAIL wrap_model: model t1=%h t2=%h, want 8000/0000", exp_q[1].t, exp_q[2].t);
    end
    send(d, hs);
    wait_drain("wrap");
    checks++;
    if (n_valid !== 3 || n_underrun !== 0) begin
      errors++;
      $display("FAIL wrap_counts: valid=%0d underrun=%0d, want 3/0", n_valid, n_underrun);
    end
  endtask

  task automatic test_reset_mid();
    seg_desc_t d;
    time hs;
    int guard;
    clear_stats();
    d = mk(16'h0AAA, 16'h0BBB, 16'h0CCC, 16'h0DDD, 16'h0100, 16'd8, 1'b1);
    push_seg(d);
    send(d, hs);
    guard = 0;
    while (n_valid < 3 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({s_ready, t_out, c0_out, c1_out, c2_out, c3_out, m_valid, m_last, busy, underrun} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: s_ready=%b t=%h c0=%h m_valid=%b busy=%b, want all 0",
               s_ready, t_out, c0_out, m_valid, busy);
    end
    exp_q.delete();
    last_exp = '{default: '0};
    repeat (2) @(negedge clk);
    checks++;
    if (s_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_ready: s_ready=%b during reset, want 0", s_ready);
    end
    #1 rstn = 1'b1;
    clear_stats();
    d = mk(16'h1357, 16'h2468, 16'h0F0F, 16'hF0F0, 16'h0300, 16'd3, 1'b1);
    push_seg(d);
    send(d, hs);
    wait_drain("reset_fresh");
    checks++;
    if (n_valid !== 3 || first_valid_t !== hs + 15 || n_underrun !== 0) begin
      errors++;
      $display("FAIL reset_fresh: valid=%0d first=%0t underrun=%0d, want 3 at %0t, 0",
               n_valid, first_valid_t, n_underrun, hs + 15);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_underrun();
    test_zero_len();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
